mips_mc_controller: RTL and testbench

- Multi-cycle MIPS control unit: the block that drives the team's 3-bit-select ALU and consumes its zero flag.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Generates ALU select, datapath mux selects and write enables from the opcode and funct fields of the instruction register.
- Sits between the instruction register and the datapath of the hmwk multi-cycle CPU.

---
 rtl/mips_ctrl_pkg.sv | 52 +++++
 rtl/alu_decoder.sv | 31 +++
 rtl/mips_mc_controller.sv | 180 ++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Contents: FSM state enum, opcode and funct field constants, ALU select
// codes, and a small helper that classifies load/store opcodes.
package mips_ctrl_pkg;

  // State encoding is visible on the debug port, so the order is fixed.
  typedef enum logic [3:0] {
    INIT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12
  } state_t;

  // Opcode field values (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct field values (IR[5:0]) for the supported R-type operations.
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU select codes understood by the 3-bit-select ALU.
  localparam logic [2:0] SEL_AND  = 3'd0;
  localparam logic [2:0] SEL_OR   = 3'd1;
  localparam logic [2:0] SEL_ADD  = 3'd2;
  localparam logic [2:0] SEL_ANDN = 3'd4;
  localparam logic [2:0] SEL_ORN  = 3'd5;
  localparam logic [2:0] SEL_SUB  = 3'd6;
  localparam logic [2:0] SEL_SLT  = 3'd7;

  // True for the two opcodes that share the MEMADR address-calculation state.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder for the multi-cycle MIPS controller.
// Ports:
//   instr_funct   in  6  funct field IR[5:0]
//   alu_sel       out 3  ALU select for the funct (ADD when unknown)
//   funct_illegal out 1  funct is not one of the supported operations
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] instr_funct,
  output logic [2:0] alu_sel,
  output logic       funct_illegal
);

  // Map funct to ALU select; unknown functs fall back to ADD and are flagged.
  always_comb begin
    alu_sel       = SEL_ADD;
    funct_illegal = 1'b0;
    case (instr_funct)
      FUNCT_ADD: alu_sel = SEL_ADD;
      FUNCT_SUB: alu_sel = SEL_SUB;
      FUNCT_AND: alu_sel = SEL_AND;
      FUNCT_OR:  alu_sel = SEL_OR;
      FUNCT_SLT: alu_sel = SEL_SLT;
      default: begin
        alu_sel       = SEL_ADD;
        funct_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit (Moore FSM).
// Sequences each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath selects, write enables and ALU select.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   instr_op, instr_funct           IR opcode and funct fields
//   alu_zero                        ALU zero flag (used by beq)
//   alu_sel, alu_src_a, alu_src_b   ALU operation and operand selects
//   pc_src, pc_en                   PC source select and load enable
//   ir_write, i_or_d, mem_write     IR load, memory address select, mem strobe
//   mem_to_reg, reg_dst, reg_write  register-file writeback controls
//   illegal                         unsupported opcode/funct (combinational)
//   state                           current FSM state, debug
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         instr_op,
  input  logic [5:0]         instr_funct,
  input  logic               alu_zero,
  output logic [2:0]         alu_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t     state_r;
  state_t     next_s;
  logic       pc_write_s;
  logic       branch_s;
  logic [2:0] dec_sel_s;
  logic       funct_illegal_s;

  alu_decoder u_alu_decoder (
    .instr_funct   (instr_funct),
    .alu_sel       (dec_sel_s),
    .funct_illegal (funct_illegal_s)
  );

  // State register; reset forces INIT so every enable drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INIT;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and Moore output decode; everything defaults to 0.
  always_comb begin
    next_s     = FETCH;
    alu_sel    = SEL_AND;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    pc_write_s = 1'b0;
    branch_s   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_r)
      INIT: begin
        next_s = FETCH;
      end
      FETCH: begin
        alu_src_b  = 2'd1;
        alu_sel    = SEL_ADD;
        ir_write   = 1'b1;
        pc_write_s = 1'b1;
        next_s     = DECODE;
      end
      DECODE: begin
        // Precompute the branch target (PC+4 + imm<<2) into ALUOut.
        alu_src_b = 2'd3;
        alu_sel   = SEL_ADD;
        if (is_mem_op(instr_op)) begin
          next_s = MEMADR;
        end else begin
          case (instr_op)
            OP_RTYPE: next_s = EXECUTE;
            OP_BEQ:   next_s = BRANCH;
            OP_ADDI:  next_s = ADDIEX;
            OP_J:     next_s = JUMP;
            default: begin
              next_s  = FETCH;
              illegal = 1'b1;
            end
          endcase
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_sel   = SEL_ADD;
        if (instr_op == OP_LW) begin
          next_s = MEMRD;
        end else begin
          next_s = MEMWR;
        end
      end
      MEMRD: begin
        i_or_d = 1'b1;
        next_s = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        next_s     = FETCH;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        next_s    = FETCH;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_sel   = dec_sel_s;
        illegal   = funct_illegal_s;
        // Unknown funct abandons the instruction without a writeback.
        if (funct_illegal_s) begin
          next_s = FETCH;
        end else begin
          next_s = ALUWB;
        end
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        next_s    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = SEL_SUB;
        pc_src    = 2'd1;
        branch_s  = 1'b1;
        next_s    = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_sel   = SEL_ADD;
        next_s    = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        next_s    = FETCH;
      end
      JUMP: begin
        pc_src     = 2'd2;
        pc_write_s = 1'b1;
        next_s     = FETCH;
      end
      default: begin
        // Unused encodings recover to FETCH with all outputs quiet.
        next_s = FETCH;
      end
    endcase
  end

  // Branch taken only when the subtract in BRANCH produced zero.
  assign pc_en = pc_write_s | (branch_s & alu_zero);
  assign state = STATE_W'(state_r);

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] instr_op;
  logic [5:0] instr_funct;
  logic       alu_zero;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mips_mc_controller #(.STATE_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_op    (instr_op),
    .instr_funct (instr_funct),
    .alu_zero    (alu_zero),
    .alu_sel     (alu_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .ir_write    (ir_write),
    .i_or_d      (i_or_d),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs: {state,sel,a,b,pc_src,pc_en,irw,iord,mw,m2r,rd,rw,ill}
  logic [19:0] act;
  assign act = {state, alu_sel, alu_src_a, alu_src_b, pc_src, pc_en, ir_write,
                i_or_d, mem_write, mem_to_reg, reg_dst, reg_write, illegal};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] pk(input logic [3:0] st, input logic [2:0] sel,
                                     input logic a, input logic [1:0] b,
                                     input logic [1:0] ps, input logic pe,
                                     input logic irw, input logic iod,
                                     input logic mw, input logic m2r,
                                     input logic rd, input logic rw,
                                     input logic ill);
    return {st, sel, a, b, ps, pe, irw, iod, mw, m2r, rd, rw, ill};
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] funct,
                     input logic zero, input logic [19:0] exp);
    vec_t v;
    v.op = op; v.funct = funct; v.zero = zero; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [19:0] got,
                       input logic [19:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%05h want=%05h", name, got, want);
    end
  endtask

  logic [19:0] e_init, e_fetch, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb, e_mwr;
  logic [19:0] e_awb, e_aex, e_aiwb, e_jmp;

  function automatic logic [19:0] e_exec(input logic [2:0] sel, input logic ill);
    return pk(4'd7, sel, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill);
  endfunction

  function automatic logic [19:0] e_br(input logic z);
    return pk(4'd9, 3'd6, 1'b1, 2'd0, 2'd1, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  initial begin
    e_init    = 20'h00000;
    e_fetch   = pk(4'd1, 3'd2, 1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_dec     = pk(4'd2, 3'd2, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_dec_ill = pk(4'd2, 3'd2, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e_madr    = pk(4'd3, 3'd2, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_mrd     = pk(4'd4, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_mwb     = pk(4'd5, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    e_mwr     = pk(4'd6, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e_awb     = pk(4'd8, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e_aex     = pk(4'd10, 3'd2, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_aiwb    = pk(4'd11, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_jmp     = pk(4'd12, 3'd0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // First check happens after reset release, before any clock edge.
    add(6'b100011, 6'd0, 1'b0, e_init);
    // lw: 5 cycles
    add(6'b100011, 6'd0, 1'b0, e_fetch);
    add(6'b100011, 6'd0, 1'b0, e_dec);
    add(6'b100011, 6'd0, 1'b0, e_madr);
    add(6'b100011, 6'd0, 1'b0, e_mrd);
    add(6'b100011, 6'd0, 1'b0, e_mwb);
    // sw: 4 cycles
    add(6'b101011, 6'd0, 1'b0, e_fetch);
    add(6'b101011, 6'd0, 1'b0, e_dec);
    add(6'b101011, 6'd0, 1'b0, e_madr);
    add(6'b101011, 6'd0, 1'b0, e_mwr);
    // R-type sub then slt
    add(6'b000000, 6'b100010, 1'b0, e_fetch);
    add(6'b000000, 6'b100010, 1'b0, e_dec);
    add(6'b000000, 6'b100010, 1'b0, e_exec(3'd6, 1'b0));
    add(6'b000000, 6'b100010, 1'b0, e_awb);
    add(6'b000000, 6'b101010, 1'b0, e_fetch);
    add(6'b000000, 6'b101010, 1'b0, e_dec);
    add(6'b000000, 6'b101010, 1'b0, e_exec(3'd7, 1'b0));
    add(6'b000000, 6'b101010, 1'b0, e_awb);
    // R-type and / or / add in EXECUTE
    add(6'b000000, 6'b100100, 1'b0, e_fetch);
    add(6'b000000, 6'b100100, 1'b0, e_dec);
    add(6'b000000, 6'b100100, 1'b0, e_exec(3'd0, 1'b0));
    add(6'b000000, 6'b100101, 1'b0, e_awb);
    add(6'b000000, 6'b100101, 1'b0, e_fetch);
    add(6'b000000, 6'b100101, 1'b0, e_dec);
    add(6'b000000, 6'b100101, 1'b0, e_exec(3'd1, 1'b0));
    add(6'b000000, 6'b100000, 1'b0, e_awb);
    add(6'b000000, 6'b100000, 1'b0, e_fetch);
    add(6'b000000, 6'b100000, 1'b0, e_dec);
    add(6'b000000, 6'b100000, 1'b0, e_exec(3'd2, 1'b0));
    add(6'b000000, 6'b100000, 1'b0, e_awb);
    // beq taken (zero held high even outside BRANCH)
    add(6'b000100, 6'd0, 1'b1, e_fetch);
    add(6'b000100, 6'd0, 1'b1, e_dec);
    add(6'b000100, 6'd0, 1'b1, e_br(1'b1));
    // beq not taken
    add(6'b000100, 6'd0, 1'b0, e_fetch);
    add(6'b000100, 6'd0, 1'b0, e_dec);
    add(6'b000100, 6'd0, 1'b0, e_br(1'b0));
    // addi
    add(6'b001000, 6'd0, 1'b0, e_fetch);
    add(6'b001000, 6'd0, 1'b0, e_dec);
    add(6'b001000, 6'd0, 1'b0, e_aex);
    add(6'b001000, 6'd0, 1'b0, e_aiwb);
    // j
    add(6'b000010, 6'd0, 1'b0, e_fetch);
    add(6'b000010, 6'd0, 1'b0, e_dec);
    add(6'b000010, 6'd0, 1'b0, e_jmp);
    // illegal opcode: ignored in FETCH, flagged in DECODE, back to FETCH
    add(6'b111111, 6'd0, 1'b0, e_fetch);
    add(6'b111111, 6'd0, 1'b0, e_dec_ill);
    // illegal funct: flagged in EXECUTE, no ALUWB afterwards
    add(6'b000000, 6'b000111, 1'b0, e_fetch);
    add(6'b000000, 6'b000111, 1'b0, e_dec);
    add(6'b000000, 6'b000111, 1'b0, e_exec(3'd2, 1'b1));
    add(6'b000000, 6'b000111, 1'b0, e_fetch);

    rst_n = 1'b0; instr_op = 6'd0; instr_funct = 6'd0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", act, e_init);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      instr_op    = vecs[i].op;
      instr_funct = vecs[i].funct;
      alu_zero    = vecs[i].zero;
      @(negedge clk);
      check($sformatf("vec%0d", i), act, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a sw write cycle.
    instr_op = 6'b101011; instr_funct = 6'd0; alu_zero = 1'b0;
    for (int n = 0; n < 20 && state !== 4'd6; n++) begin
      @(posedge clk);
      #1;
    end
    check("reach_memwr", {16'd0, state}, 20'd6);
    @(negedge clk);
    check("memwr_strobe", act, e_mwr);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", act, e_init);
    @(posedge clk);
    #1;
    check("reset_held", act, e_init);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_init", act, e_init);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_fetch", act, e_fetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
